// File: rtl/sp_pkg.sv
// Shared types and widths for the sample receiver block.
package sp_pkg;

  // Default signed sample width and the non-wrapping accumulator width.
  localparam int DW   = 10;
  localparam int SUMW = DW + 4;

  // Width of the burst length / read pointer counters (0..16).
  localparam int LENW = 5;

  // Receiver control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sp_rx_if.sv
// Sample-in / host-read / summary bundle between the producer-host side and sp_rx.
interface sp_rx_if
  import sp_pkg::*;
#(
  parameter int DW = sp_pkg::DW
);

  logic                     in_valid;
  logic signed [DW-1:0]     in_data;
  logic                     rd_req;
  logic                     rd_valid;
  logic signed [DW-1:0]     rd_data;
  logic                     done;
  logic [LENW-1:0]          burst_len;
  logic signed [DW+3:0]     sum;
  logic signed [DW-1:0]     max_v;
  logic signed [DW-1:0]     min_v;
  logic                     ovf;

  // Producer/host side.
  modport master (
    output in_valid, in_data, rd_req,
    input  rd_valid, rd_data, done, burst_len, sum, max_v, min_v, ovf
  );

  // Receiver side.
  modport slave (
    input  in_valid, in_data, rd_req,
    output rd_valid, rd_data, done, burst_len, sum, max_v, min_v, ovf
  );

endinterface

// File: rtl/sp_rx_buf.sv
// DEPTH x DW sample register file: one write port, one registered read port.
// The storage array has no reset; entries are only read after being written.
module sp_rx_buf #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 10,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cg_en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;
  logic          wclk_en_s;

  // Write-clock enable: with gating on, the array only sees clock on writes;
  // with gating off it is free-running. Either way only `we` changes contents.
  assign wclk_en_s = we | ~cg_en;

  // Storage array write (gated clock domain, no reset).
  always_ff @(posedge clk) begin
    if (wclk_en_s && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read-port next value: capture on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Registered read data, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DW{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sp_rx.sv
// Burst sample receiver: buffers one burst, reports length/sum/max/min,
// then lets the host pop the buffered samples with one-cycle latency.
module sp_rx
  import sp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = sp_pkg::DW
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cg_en,
  sp_rx_if.slave  bus
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              SW      = DW + 4;
  localparam logic [LENW-1:0] DEPTH_L = LENW'(DEPTH);
  localparam logic [LENW-1:0] ONE_L   = LENW'(1);

  state_e                 state_q, state_d;
  logic [LENW-1:0]        count_q, count_d;
  logic [LENW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic signed [DW-1:0]   max_q, max_d;
  logic signed [DW-1:0]   min_q, min_d;

  logic                   we_s;
  logic                   re_s;
  logic [AW-1:0]          waddr_s;
  logic signed [DW-1:0]   samp_s;
  logic signed [SW-1:0]   samp_ext_s;
  logic [DW-1:0]          rdata_s;

  assign samp_s     = bus.in_data;
  assign samp_ext_s = {{4{samp_s[DW-1]}}, samp_s};

  // Next-state, accumulator and buffer-port control for the receive/read sequence.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    done_d     = done_q;
    ovf_d      = ovf_q;
    sum_d      = sum_q;
    max_d      = max_q;
    min_d      = min_q;
    we_s       = 1'b0;
    re_s       = 1'b0;
    waddr_s    = {AW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d  = ST_RECV;
          we_s     = 1'b1;
          waddr_s  = {AW{1'b0}};
          count_d  = ONE_L;
          rd_ptr_d = {LENW{1'b0}};
          sum_d    = samp_ext_s;
          max_d    = samp_s;
          min_d    = samp_s;
          ovf_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (bus.in_valid) begin
          if (count_q < DEPTH_L) begin
            we_s    = 1'b1;
            waddr_s = count_q[AW-1:0];
            count_d = count_q + ONE_L;
            sum_d   = sum_q + samp_ext_s;
            max_d   = (samp_s > max_q) ? samp_s : max_q;
            min_d   = (samp_s < min_q) ? samp_s : min_q;
          end else begin
            // Buffer full: drop the sample, keep the summary, flag overflow.
            ovf_d = 1'b1;
          end
        end else begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          rd_ptr_d = {LENW{1'b0}};
        end
      end
      ST_DONE: begin
        if (bus.in_valid) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (rd_ptr_q == count_q) begin
          // Everything popped: leave DONE; any rd_req here is ignored.
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (bus.rd_req) begin
          re_s       = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + ONE_L;
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // Control FSM and registered summary/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= {LENW{1'b0}};
      rd_ptr_q   <= {LENW{1'b0}};
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      sum_q      <= {SW{1'b0}};
      max_q      <= {DW{1'b0}};
      min_q      <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      min_q      <= min_d;
    end
  end

  sp_rx_buf #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .cg_en (cg_en),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (samp_s),
    .re    (re_s),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata_s)
  );

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rdata_s;
  assign bus.done      = done_q;
  assign bus.burst_len = count_q;
  assign bus.sum       = sum_q;
  assign bus.max_v     = max_q;
  assign bus.min_v     = min_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sp_rx.sv
// Directed self-checking bench for sp_rx.
module tb_sp_rx;

  logic clk;
  logic rst_n;
  logic cg_en;
  int   errors;
  int   checks;

  sp_rx_if #(.DW(10)) bus ();

  sp_rx #(
    .DEPTH (16),
    .DW    (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cg_en (cg_en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'(v);
    tick();
  endtask

  task automatic end_burst();
    bus.in_valid = 1'b0;
    bus.in_data  = 10'(0);
    tick();
  endtask

  task automatic pop_chk(input string tag, input int exp);
    bus.rd_req = 1'b1;
    tick();
    chk({tag, "_rd_valid"}, bus.rd_valid, 1);
    chk({tag, "_rd_data"}, bus.rd_data, exp);
  endtask

  task automatic drain(input int n);
    bus.rd_req = 1'b1;
    repeat (n) tick();
    bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic chk_summary(input string tag, input int bl, input int s, input int mx, input int mn, input int ov);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_burst_len"}, bus.burst_len, bl);
    chk({tag, "_sum"}, bus.sum, s);
    chk({tag, "_max"}, bus.max_v, mx);
    chk({tag, "_min"}, bus.min_v, mn);
    chk({tag, "_ovf"}, bus.ovf, ov);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_burst_len"}, bus.burst_len, 0);
    chk({tag, "_sum"}, bus.sum, 0);
    chk({tag, "_max"}, bus.max_v, 0);
    chk({tag, "_min"}, bus.min_v, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    cg_en        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 10'(0);
    bus.rd_req   = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Burst {3,-5,7}, pops with one-cycle latency, then back to IDLE.
    drive(3);
    drive(-5);
    drive(7);
    chk("b1_not_done_yet", bus.done, 0);
    end_burst();
    chk_summary("b1", 3, 5, 7, -5, 0);
    chk("b1_no_rd_valid_before_pop", bus.rd_valid, 0);
    pop_chk("b1_pop0", 3);
    pop_chk("b1_pop1", -5);
    pop_chk("b1_pop2", 7);
    bus.rd_req = 1'b0;
    tick();
    chk("b1_idle_done", bus.done, 0);
    chk("b1_idle_rd_valid", bus.rd_valid, 0);
    chk("b1_hold_len", bus.burst_len, 3);
    chk("b1_hold_sum", bus.sum, 5);
    bus.rd_req = 1'b1;
    tick();
    chk("idle_rd_req_ignored", bus.rd_valid, 0);
    bus.rd_req = 1'b0;
    tick();

    // Overlong burst: 18 ones, count saturates at 16.
    cg_en = 1'b1;
    for (int i = 0; i < 18; i++) drive(1);
    end_burst();
    chk_summary("b2", 16, 16, 1, 1, 1);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("b2_pop%0d_valid", i), bus.rd_valid, 1);
      chk($sformatf("b2_pop%0d_data", i), bus.rd_data, 1);
    end
    tick();
    chk("b2_extra_rd_req", bus.rd_valid, 0);
    chk("b2_done_fell", bus.done, 0);
    bus.rd_req = 1'b0;
    tick();

    // Single most-negative sample; new burst clears ovf.
    drive(-512);
    end_burst();
    chk_summary("b3", 1, -512, -512, -512, 0);
    pop_chk("b3_pop0", -512);
    bus.rd_req = 1'b0;
    tick();

    // Full-scale sums do not wrap.
    for (int i = 0; i < 16; i++) drive(511);
    end_burst();
    chk_summary("b4_pos", 16, 8176, 511, 511, 0);
    drain(16);
    chk("b4_pos_idle", bus.done, 0);
    for (int i = 0; i < 16; i++) drive(-512);
    end_burst();
    chk_summary("b4_neg", 16, -8192, -512, -512, 0);
    drain(16);
    chk("b4_neg_idle", bus.done, 0);

    // Sample arriving in DONE is dropped and flags ovf; buffer intact.
    drive(10);
    drive(-20);
    end_burst();
    drive(99);
    bus.in_valid = 1'b0;
    chk_summary("b5", 2, -10, 10, -20, 1);
    pop_chk("b5_pop0", 10);
    pop_chk("b5_pop1", -20);
    tick();
    chk("b5_extra_rd_req", bus.rd_valid, 0);
    bus.rd_req = 1'b0;
    tick();

    // Reset mid-burst, then a fresh one-sample burst, with gating off and on.
    for (int c = 0; c < 2; c++) begin
      cg_en = (c == 1) ? 1'b1 : 1'b0;
      drive(1);
      drive(2);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      #2;
      chk_zero($sformatf("midrst_cg%0d", c));
      rst_n = 1'b1;
      tick();
      drive(4);
      end_burst();
      chk_summary($sformatf("b6_cg%0d", c), 1, 4, 4, 4, 0);
      pop_chk($sformatf("b6_cg%0d_pop0", c), 4);
      bus.rd_req = 1'b0;
      tick();
      chk($sformatf("b6_cg%0d_idle", c), bus.done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_rx.md
SP_RX -- requirements
Module: sp_rx

Interface
REQ-001 Parameter DEPTH, default 16, sample buffer entries (power of two, 2..16).
REQ-002 Parameter DW, default 10, signed sample width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cg_en  input  1  clock-gating enable for buffer registers; behaviour at ports is identical for cg_en=0 and cg_en=1.
REQ-006 in_valid  input  1  sample strobe, driven from SP out_valid; a burst is a maximal run of consecutive high cycles.
REQ-007 in_data  input  DW  signed sample, driven from SP out_data, valid when in_valid=1.
REQ-008 rd_req  input  1  host pops one buffered sample per cycle.
REQ-009 rd_valid  output  1  rd_data holds a popped sample this cycle.
REQ-010 rd_data  output  DW  signed popped sample.
REQ-011 done  output  1  burst complete; summary outputs valid.
REQ-012 burst_len  output  5  samples stored in the last burst (0..DEPTH).
REQ-013 sum  output  DW+4  signed sum of stored samples.
REQ-014 max_v / min_v  output  DW each  signed max/min of stored samples.
REQ-015 ovf  output  1  last burst exceeded DEPTH, or a burst arrived in DONE.

Function
REQ-016 FSM states IDLE, RECV, DONE; reset state IDLE.
REQ-017 IDLE: in_valid=1 -> RECV; the sample is stored at index 0, sum=sample, max_v=min_v=sample, count=1, ovf cleared.
REQ-018 RECV: each in_valid=1 cycle stores the sample at index count, updates sum/max/min, and increments count.
REQ-019 RECV: the first in_valid=0 cycle -> DONE; done rises on the following cycle and holds until DONE is left.
REQ-020 When count=DEPTH, further samples in the same burst are discarded, leave sum/max/min unchanged, and set ovf; count saturates at DEPTH.
REQ-021 Signed comparison for max/min; sum is sign-extended to DW+4 and never wraps for DEPTH<=16.
REQ-022 DONE: rd_req=1 pops the entry at rd_ptr; rd_valid=1 and rd_data=entry in the next cycle (1-cycle read latency); rd_ptr increments.
REQ-023 rd_req while rd_ptr=burst_len is ignored, with rd_valid=0.
REQ-024 DONE -> IDLE the cycle after the last entry is popped; done falls in that same transition.
REQ-025 in_valid=1 in DONE: the sample is dropped and ovf is set; buffered data is untouched.
REQ-026 rd_req outside DONE is ignored.
REQ-027 burst_len, sum, max_v and min_v hold their values from done until the next burst starts.

Reset
REQ-028 Asynchronous assertion of rst_n=0 forces state IDLE, and count, rd_ptr, rd_valid, done and ovf to 0.
REQ-029 Reset forces rd_data, burst_len, sum, max_v and min_v to 0.
REQ-030 Buffer contents are not reset; they are unobservable until rewritten.
REQ-031 Reset mid-burst or mid-read discards everything; the first in_valid after release starts a new burst.

Structure
REQ-032 A shared package sp_pkg holds the state enum, DW, and SUMW=DW+4.
REQ-033 One sub-module, sp_rx_buf: a DEPTH x DW register file with write port, 1-cycle registered read port and cg_en-gated write clock.

Verification
REQ-034 Burst {3,-5,7} -> done; burst_len=3, sum=5, max_v=7, min_v=-5; three pops return 3,-5,7 with 1-cycle latency; then IDLE.
REQ-035 Burst of 18 samples of value 1 -> burst_len=16, sum=16, ovf=1; 16 pops each return 1.
REQ-036 Single sample -512 -> burst_len=1, sum=-512, max_v=min_v=-512.
REQ-037 16 samples of 511 -> sum=8176; 16 samples of -512 -> sum=-8192; no wrap in either case.
REQ-038 in_valid pulse during DONE -> ovf=1 and the earlier burst reads back intact; extra rd_req after the last pop -> rd_valid=0.
REQ-039 rst_n low mid-burst (after 2 of 4 samples) -> all outputs 0; next burst {4} -> burst_len=1, sum=4; repeat with cg_en=0 and cg_en=1 and require identical results.
